// File: rtl/rca_seq_pkg.sv
// Shared types and constants for the nibble-serial adder controller.
//   state_t : controller FSM states (IDLE, RUN, DONE)
//   NIB_W   : width of the ripple-carry slice, in bits
package rca_seq_pkg;

  localparam int NIB_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage : rca_seq_pkg

// File: rtl/rca_nibble.sv
// Purely combinational 4-bit ripple-carry adder slice built from four
// full-adder bit cells.
// Ports:
//   x, y : nibble operands
//   ci   : carry into bit 0
//   s    : nibble sum
//   co   : carry out of bit 3
module rca_nibble
  import rca_seq_pkg::*;
(
  input  logic [NIB_W-1:0] x,
  input  logic [NIB_W-1:0] y,
  input  logic             ci,
  output logic [NIB_W-1:0] s,
  output logic             co
);

  logic [NIB_W:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < NIB_W; i++) begin : g_fa
    assign s[i]   = x[i] ^ y[i] ^ c[i];
    assign c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
  end

  assign co = c[NIB_W];

endmodule : rca_nibble

// File: rtl/rca_seq_ctrl.sv
// Sequencing controller: WIDTH-bit addition by time-multiplexing one 4-bit
// ripple-carry slice, one nibble per clock, LSB nibble first.
// Ports:
//   clk, rst_n           : clock, synchronous active-low reset
//   in_valid / in_ready  : operand handshake (a, b, cin)
//   out_valid / out_ready: result handshake (sum, cout, ovf)
//   sum                  : a + b + cin modulo 2^WIDTH
//   cout                 : carry out of bit WIDTH-1
//   ovf                  : two's-complement signed overflow
// WIDTH must be a multiple of 4 and at least 8.
module rca_seq_ctrl
  import rca_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NIB   = WIDTH / NIB_W;
  localparam int CNT_W = (NIB > 1) ? $clog2(NIB) : 1;

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic             carry;
  logic [WIDTH-1:0] a_sr, b_sr, sum_r;
  logic             a_msb, b_msb;
  logic             cout_r, ovf_r;

  logic [NIB_W-1:0] slice_s;
  logic             slice_co;
  logic             accept;
  logic             last;

  rca_nibble u_slice (
    .x  (a_sr[NIB_W-1:0]),
    .y  (b_sr[NIB_W-1:0]),
    .ci (carry),
    .s  (slice_s),
    .co (slice_co)
  );

  assign accept = in_valid && in_ready;
  assign last   = (cnt == CNT_W'(NIB - 1));

  // Next state and handshake outputs; both depend only on the state flops
  // (plus the handshake inputs for the transition itself).
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = RUN;
      end
      RUN: begin
        if (last) state_nx = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Control state and result registers, all cleared by reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      carry  <= 1'b0;
      sum_r  <= '0;
      cout_r <= 1'b0;
      ovf_r  <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        carry <= cin;
        cnt   <= '0;
      end else if (state == RUN) begin
        // Slice result enters at the top; after NIB shifts nibble 0 sits at
        // the bottom.
        sum_r <= {slice_s, sum_r[WIDTH-1:NIB_W]};
        carry <= slice_co;
        if (last) begin
          cout_r <= slice_co;
          // slice_s[NIB_W-1] is the final sum MSB.
          ovf_r  <= (a_msb == b_msb) && (slice_s[NIB_W-1] != a_msb);
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
    end
  end

  // Operand shift registers and sign capture.
  // NOTE: pure datapath registers carry no reset; they are always loaded on
  // accept before being consumed, so resetting them buys nothing.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_sr  <= a;
      b_sr  <= b;
      a_msb <= a[WIDTH-1];
      b_msb <= b[WIDTH-1];
    end else if (state == RUN) begin
      a_sr <= a_sr >> NIB_W;
      b_sr <= b_sr >> NIB_W;
    end
  end

  assign sum  = sum_r;
  assign cout = cout_r;
  assign ovf  = ovf_r;

endmodule : rca_seq_ctrl

// File: tb/tb_rca_seq_ctrl.sv
// Directed self-checking bench for rca_seq_ctrl (WIDTH=16).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_rca_seq_ctrl;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        cout;
  logic        ovf;

  int checks = 0;
  int errors = 0;

  rca_seq_ctrl #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one operand bundle from IDLE and wait for the result; leaves the
  // bench at the falling edge where out_valid was first seen.
  task automatic do_op(input string tag, input logic [15:0] oa, input logic [15:0] ob,
                       input logic oc, input logic [15:0] es, input logic ec,
                       input logic eo, input bit hold_valid);
    int lat;
    check({tag, " in_ready before accept"}, 32'(in_ready), 32'd1);
    a        = oa;
    b        = ob;
    cin      = oc;
    in_valid = 1'b1;
    @(negedge clk);
    if (!hold_valid) in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check({tag, " latency"}, 32'(lat), 32'd4);
    check({tag, " sum"}, 32'(sum), 32'(es));
    check({tag, " cout"}, 32'(cout), 32'(ec));
    check({tag, " ovf"}, 32'(ovf), 32'(eo));
  endtask

  // Complete the result handshake and confirm the return to IDLE.
  task automatic take_result(input string tag);
    out_ready = 1'b1;
    @(negedge clk);
    check({tag, " in_ready after take"}, 32'(in_ready), 32'd1);
    check({tag, " out_valid after take"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    logic [15:0] ra, rb;
    logic        rc;
    logic [16:0] full;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    cin       = 1'b0;
    repeat (2) @(negedge clk);
    check("reset in_ready", 32'(in_ready), 32'd1);
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset sum", 32'(sum), 32'd0);
    check("reset cout", 32'(cout), 32'd0);
    check("reset ovf", 32'(ovf), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Plain addition, then hold the result under back-pressure while new
    // operands are offered.
    do_op("add1234", 16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0, 1'b0);
    a        = 16'hAAAA;
    b        = 16'h5555;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold sum", 32'(sum), 32'h2345);
      check("hold cout", 32'(cout), 32'd0);
      check("hold ovf", 32'(ovf), 32'd0);
      check("hold in_ready", 32'(in_ready), 32'd0);
      check("hold out_valid", 32'(out_valid), 32'd1);
    end
    in_valid = 1'b0;
    take_result("add1234");
    check("idle keeps sum", 32'(sum), 32'h2345);
    out_ready = 1'b0;

    // Carry ripples through every nibble.
    do_op("ripple", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    take_result("ripple");
    out_ready = 1'b0;

    // Positive overflow via carry-in, then negative overflow.
    do_op("posovf", 16'h7FFF, 16'h0000, 1'b1, 16'h8000, 1'b0, 1'b1, 1'b0);
    take_result("posovf");
    out_ready = 1'b0;
    do_op("negovf", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0);
    take_result("negovf");
    out_ready = 1'b0;

    // Reset during the second RUN cycle discards the operation.
    a        = 16'h1234;
    b        = 16'h4321;
    cin      = 1'b0;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrun rst in_ready", 32'(in_ready), 32'd1);
    check("midrun rst out_valid", 32'(out_valid), 32'd0);
    check("midrun rst sum", 32'(sum), 32'd0);
    check("midrun rst cout", 32'(cout), 32'd0);
    check("midrun rst ovf", 32'(ovf), 32'd0);
    rst_n = 1'b1;
    do_op("after rst", 16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0);
    take_result("after rst");

    // Back-to-back with in_valid and out_ready held high: each operation
    // takes exactly 6 cycles (4-cycle latency plus take plus re-accept).
    out_ready = 1'b1;
    for (int k = 0; k < 200; k++) begin
      ra   = 16'($urandom);
      rb   = 16'($urandom);
      rc   = 1'($urandom_range(0, 1));
      full = {1'b0, ra} + {1'b0, rb} + {16'd0, rc};
      do_op("b2b", ra, rb, rc, full[15:0], full[16],
            (ra[15] == rb[15]) && (full[15] != ra[15]), 1'b1);
      take_result("b2b");
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_rca_seq_ctrl
